// File: rtl/mb_rx_pkg.sv
// Shared types and constants for the mainband RX deserializer.
// The optional valid-lane checker is enabled with MB_RX_VALID_CHECK_EN.
package mb_rx_pkg;

  typedef enum logic {
    MB_RX_IDLE  = 1'b0,
    MB_RX_SHIFT = 1'b1
  } mb_rx_state_e;

  localparam int MB_RX_DATA_WIDTH = 32;

  // Expected VALID_IN per bit index [2:0], LSB is bit 0 of each octet
  localparam logic [7:0] MB_RX_VALID_PAT = 8'b0000_1111;

endpackage

// File: rtl/mb_rx_deserializer_if.sv
// Serial-in / parallel-out bus of the mainband RX deserializer.
// VALID_IN/VALID_ERR exist only when MB_RX_VALID_CHECK_EN is defined.
interface mb_rx_deserializer_if #(
  parameter int DATA_WIDTH = mb_rx_pkg::MB_RX_DATA_WIDTH
);
  logic                  SER_IN;
  logic                  DES_EN;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  WORD_ABORT;
`ifdef MB_RX_VALID_CHECK_EN
  logic                  VALID_IN;
  logic                  VALID_ERR;

  modport master (output SER_IN, DES_EN, VALID_IN,
                  input  P_DATA, DATA_VALID, WORD_ABORT, VALID_ERR);
  modport slave  (input  SER_IN, DES_EN, VALID_IN,
                  output P_DATA, DATA_VALID, WORD_ABORT, VALID_ERR);
`else
  modport master (output SER_IN, DES_EN,
                  input  P_DATA, DATA_VALID, WORD_ABORT);
  modport slave  (input  SER_IN, DES_EN,
                  output P_DATA, DATA_VALID, WORD_ABORT);
`endif
endinterface

// File: rtl/mb_rx_valid_checker.sv
// Sticky checker comparing the valid lane against the 4-high/4-low pattern.
// Only instantiated when MB_RX_VALID_CHECK_EN is defined.
module mb_rx_valid_checker
  import mb_rx_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] bit_idx,
  input  logic       valid_in,
  input  logic       sample_en,
  input  logic       clr,
  output logic       err
);

  logic [7:0] pat;
  assign pat = MB_RX_VALID_PAT;

  always_ff @(posedge CLK) begin
    if (RST)
      err <= 1'b0;
    else if (clr)
      err <= 1'b0;
    else if (sample_en && (valid_in != pat[bit_idx]))
      err <= 1'b1;
  end

endmodule

// File: rtl/mb_rx_deserializer.sv
// Mainband RX deserializer: LSB-first serial lane to DATA_WIDTH-bit words.
// Optional valid-lane pattern checking under MB_RX_VALID_CHECK_EN.
module mb_rx_deserializer
  import mb_rx_pkg::*;
#(
  parameter int DATA_WIDTH    = MB_RX_DATA_WIDTH,
  parameter int COUNTER_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                 CLK,
  input  logic                 RST,
  mb_rx_deserializer_if.slave  bus
);

  localparam logic [COUNTER_WIDTH-1:0] LAST_IDX = COUNTER_WIDTH'(DATA_WIDTH - 1);

  mb_rx_state_e              state, state_nxt;
  logic [COUNTER_WIDTH-1:0]  cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0]     sreg, sreg_nxt;
  logic [DATA_WIDTH-1:0]     p_data, p_data_nxt;
  logic                      dv, dv_nxt;
  logic                      wa, wa_nxt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= MB_RX_IDLE;
      cnt    <= '0;
      sreg   <= '0;
      p_data <= '0;
      dv     <= 1'b0;
      wa     <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      sreg   <= sreg_nxt;
      p_data <= p_data_nxt;
      dv     <= dv_nxt;
      wa     <= wa_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    sreg_nxt   = sreg;
    p_data_nxt = p_data;
    dv_nxt     = 1'b0;
    wa_nxt     = 1'b0;
    unique case (state)
      MB_RX_IDLE: begin
        if (bus.DES_EN) begin
          sreg_nxt[0] = bus.SER_IN;
          cnt_nxt     = COUNTER_WIDTH'(1);
          state_nxt   = MB_RX_SHIFT;
        end
      end
      MB_RX_SHIFT: begin
        if (bus.DES_EN) begin
          sreg_nxt[cnt] = bus.SER_IN;
          cnt_nxt       = cnt + 1'b1;
          // Last bit: the counter wraps to 0 and the word is published
          if (cnt == LAST_IDX) begin
            p_data_nxt = {bus.SER_IN, sreg[DATA_WIDTH-2:0]};
            dv_nxt     = 1'b1;
          end
        end else begin
          wa_nxt    = (cnt != '0);
          cnt_nxt   = '0;
          state_nxt = MB_RX_IDLE;
        end
      end
      default: state_nxt = MB_RX_IDLE;
    endcase
  end

  assign bus.P_DATA     = p_data;
  assign bus.DATA_VALID = dv;
  assign bus.WORD_ABORT = wa;

`ifdef MB_RX_VALID_CHECK_EN
  mb_rx_valid_checker u_vchk (
    .CLK       (CLK),
    .RST       (RST),
    .bit_idx   (cnt[2:0]),
    .valid_in  (bus.VALID_IN),
    .sample_en (bus.DES_EN),
    .clr       ((state == MB_RX_IDLE) && !bus.DES_EN),
    .err       (bus.VALID_ERR)
  );
`endif

endmodule

// File: tb/tb_mb_rx_deserializer.sv
// Scoreboard bench for mb_rx_deserializer; valid-lane scenario runs
// when MB_RX_VALID_CHECK_EN is defined.
module tb_mb_rx_deserializer;
  import mb_rx_pkg::*;

  localparam int DW = 32;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  mb_rx_deserializer_if #(.DATA_WIDTH(DW)) bus ();

  mb_rx_deserializer #(.DATA_WIDTH(DW), .COUNTER_WIDTH(5)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int dv_cnt = 0;
  int wa_cnt = 0;
  int last_dv_cyc = 0;
  int prev_dv_cyc = 0;
  int vbad_idx = -1;
  logic [DW-1:0] exp_q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: pop expected words on every DATA_VALID strobe
  always @(negedge CLK) begin
    if (!RST) begin
      if (bus.DATA_VALID) begin
        dv_cnt++;
        prev_dv_cyc = last_dv_cyc;
        last_dv_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_dv got P_DATA=%h with empty scoreboard", bus.P_DATA);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          if (bus.P_DATA !== e) begin
            errors++;
            $display("FAIL word got %h expected %h", bus.P_DATA, e);
          end
        end
      end
      if (bus.WORD_ABORT) wa_cnt++;
      if (bus.DATA_VALID && bus.WORD_ABORT) begin
        checks++;
        errors++;
        $display("FAIL dv_wa_overlap got both high expected exclusive");
      end
    end
  end

  function automatic logic vpat(int i);
    logic [7:0] p;
    p = MB_RX_VALID_PAT;
    return (i == vbad_idx) ? 1'b0 : p[i % 8];
  endfunction

  task automatic drive_bit(input logic b, input int idx);
    bus.SER_IN = b;
    bus.DES_EN = 1'b1;
`ifdef MB_RX_VALID_CHECK_EN
    bus.VALID_IN = vpat(idx);
`else
    if (idx < 0) bus.SER_IN = b;
`endif
    @(posedge CLK); #1;
  endtask

  task automatic send_bits(input logic [DW-1:0] w, input int n);
    for (int i = 0; i < n; i++) drive_bit(w[i], i);
  endtask

  task automatic idle(input int n);
    bus.DES_EN = 1'b0;
    bus.SER_IN = 1'b0;
`ifdef MB_RX_VALID_CHECK_EN
    bus.VALID_IN = 1'b0;
`endif
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    idle(3);
    checks++;
    if (bus.P_DATA !== '0 || bus.DATA_VALID !== 1'b0 || bus.WORD_ABORT !== 1'b0) begin
      errors++;
      $display("FAIL reset got P_DATA=%h DV=%b WA=%b expected 0/0/0",
               bus.P_DATA, bus.DATA_VALID, bus.WORD_ABORT);
    end
`ifdef MB_RX_VALID_CHECK_EN
    checks++;
    if (bus.VALID_ERR !== 1'b0) begin
      errors++;
      $display("FAIL reset_verr got %b expected 0", bus.VALID_ERR);
    end
`endif
    RST = 1'b0;
    idle(1);
  endtask

  task automatic test_single();
    int dv0;
    dv0 = dv_cnt;
    exp_q.push_back(32'hA5A5_3C3C);
    send_bits(32'hA5A5_3C3C, 31);
    checks++;
    if (bus.DATA_VALID !== 1'b0) begin
      errors++;
      $display("FAIL early_dv got %b expected 0 before last bit", bus.DATA_VALID);
    end
    drive_bit(1'b1, 31);
    bus.DES_EN = 1'b0;
    checks++;
    if (bus.DATA_VALID !== 1'b1 || bus.P_DATA !== 32'hA5A5_3C3C) begin
      errors++;
      $display("FAIL latency got DV=%b P_DATA=%h expected 1/a5a53c3c",
               bus.DATA_VALID, bus.P_DATA);
    end
    idle(3);
    checks++;
    if (dv_cnt - dv0 !== 1 || wa_cnt !== 0) begin
      errors++;
      $display("FAIL single_pulses got dv=%0d wa=%0d expected 1/0", dv_cnt - dv0, wa_cnt);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(32'h0000_0001);
    exp_q.push_back(32'h8000_0000);
    send_bits(32'h0000_0001, 32);
    send_bits(32'h8000_0000, 32);
    idle(2);
    checks++;
    if (last_dv_cyc - prev_dv_cyc !== 32) begin
      errors++;
      $display("FAIL b2b_spacing got %0d expected 32", last_dv_cyc - prev_dv_cyc);
    end
    checks++;
    if (bus.P_DATA !== 32'h8000_0000) begin
      errors++;
      $display("FAIL b2b_hold got %h expected 80000000", bus.P_DATA);
    end
  endtask

  task automatic test_abort();
    int wa0, dv0;
    wa0 = wa_cnt;
    dv0 = dv_cnt;
    send_bits(32'hFFFF_FFFF, 17);
    bus.DES_EN = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (bus.WORD_ABORT !== 1'b1 || bus.P_DATA !== 32'h8000_0000) begin
      errors++;
      $display("FAIL abort got WA=%b P_DATA=%h expected 1/80000000",
               bus.WORD_ABORT, bus.P_DATA);
    end
    // Re-enable immediately after the drop cycle
    exp_q.push_back(32'hDEAD_BEEF);
    send_bits(32'hDEAD_BEEF, 32);
    idle(2);
    checks++;
    if (wa_cnt - wa0 !== 1 || dv_cnt - dv0 !== 1) begin
      errors++;
      $display("FAIL abort_pulses got wa=%0d dv=%0d expected 1/1", wa_cnt - wa0, dv_cnt - dv0);
    end
    checks++;
    if (bus.P_DATA !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL abort_next got %h expected deadbeef", bus.P_DATA);
    end
  endtask

  task automatic test_reset_mid();
    int wa0, dv0;
    wa0 = wa_cnt;
    dv0 = dv_cnt;
    send_bits(32'hFFFF_FFFF, 20);
    RST = 1'b1;
    drive_bit(1'b1, 20);
    RST = 1'b0;
    idle(2);
    checks++;
    if (wa_cnt !== wa0 || dv_cnt !== dv0 || bus.P_DATA !== '0) begin
      errors++;
      $display("FAIL reset_mid got wa=%0d dv=%0d P_DATA=%h expected 0/0/0",
               wa_cnt - wa0, dv_cnt - dv0, bus.P_DATA);
    end
    exp_q.push_back(32'h1234_5678);
    send_bits(32'h1234_5678, 32);
    idle(2);
    checks++;
    if (bus.P_DATA !== 32'h1234_5678 || dv_cnt - dv0 !== 1) begin
      errors++;
      $display("FAIL reset_mid_next got %h dv=%0d expected 12345678/1",
               bus.P_DATA, dv_cnt - dv0);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      logic [DW-1:0] w;
      w = $urandom;
      exp_q.push_back(w);
      send_bits(w, 32);
    end
    idle(2);
  endtask

`ifdef MB_RX_VALID_CHECK_EN
  task automatic test_valid();
    logic [DW-1:0] w;
    vbad_idx = -1;
    w = 32'h0F0F_5A5A;
    exp_q.push_back(w);
    send_bits(w, 32);
    checks++;
    if (bus.VALID_ERR !== 1'b0) begin
      errors++;
      $display("FAIL verr_clean got %b expected 0", bus.VALID_ERR);
    end
    vbad_idx = 2;
    w = 32'h3333_CCCC;
    exp_q.push_back(w);
    send_bits(w, 2);
    checks++;
    if (bus.VALID_ERR !== 1'b0) begin
      errors++;
      $display("FAIL verr_before got %b expected 0", bus.VALID_ERR);
    end
    drive_bit(w[2], 2);
    checks++;
    if (bus.VALID_ERR !== 1'b1) begin
      errors++;
      $display("FAIL verr_set got %b expected 1", bus.VALID_ERR);
    end
    for (int i = 3; i < 32; i++) drive_bit(w[i], i);
    vbad_idx = -1;
    idle(1);
    checks++;
    if (bus.VALID_ERR !== 1'b1) begin
      errors++;
      $display("FAIL verr_sticky got %b expected 1 at SHIFT->IDLE", bus.VALID_ERR);
    end
    idle(1);
    checks++;
    if (bus.VALID_ERR !== 1'b0) begin
      errors++;
      $display("FAIL verr_clear got %b expected 0 after idle", bus.VALID_ERR);
    end
  endtask
`endif

  initial begin
    bus.SER_IN = 1'b0;
    bus.DES_EN = 1'b0;
`ifdef MB_RX_VALID_CHECK_EN
    bus.VALID_IN = 1'b0;
`endif
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
`ifdef MB_RX_VALID_CHECK_EN
    test_valid();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mb_rx_deserializer.md
# mb_rx_deserializer

Mainband receive-side deserializer, the direct downstream counterpart of the mainband TX serializer. It samples one serial data lane per clock while the lane is enabled, LSB first, and assembles `DATA_WIDTH`-bit parallel words. It emits each completed word with a one-cycle `DATA_VALID` strobe and flags words cut short by enable de-assertion. It feeds the mainband RX lane-deskew/FIFO stage.

## Interface
- `DATA_WIDTH`, 32, parallel word width; must be a power of two, 8 or greater.
- `COUNTER_WIDTH`, 5, bit-index counter width; equals log2(`DATA_WIDTH`).
- `CLK`  in  1  receive clock, one UI per rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `SER_IN`  in  1  serial data; bit 0 of each word arrives first.
- `DES_EN`  in  1  lane enable; high while serial bits are valid.
- `VALID_IN`  in  1  UCIe valid-lane sample; present only with `MB_RX_VALID_CHECK_EN`.
- `P_DATA`  out  `DATA_WIDTH`  last completed word; holds until the next word completes.
- `DATA_VALID`  out  1  one-cycle strobe, `P_DATA` is new.
- `WORD_ABORT`  out  1  one-cycle strobe, partial word discarded.
- `VALID_ERR`  out  1  sticky valid-pattern error; present only with `MB_RX_VALID_CHECK_EN`.

## Operation
- FSM with two states: IDLE and SHIFT.
- In IDLE:
  - On `DES_EN`=1, sample `SER_IN` into shift-register bit 0, set the counter to 1, and go to SHIFT.
  - The first-bit sample and the state change happen on the same edge.
- In SHIFT:
  - Each cycle with `DES_EN`=1, write `SER_IN` into bit [counter] and increment the counter.
  - When the counter equals `DATA_WIDTH`-1, that sample is the last bit of the word:
    - Load `P_DATA` with the full word (previous bits plus `SER_IN` in the MSB).
    - Pulse `DATA_VALID` and reset the counter to 0.
    - Stay in SHIFT, so back-to-back words have no gap.
  - Counter arithmetic is modulo 2^`COUNTER_WIDTH`; wrap from `DATA_WIDTH`-1 to 0 coincides with word completion.
- `DES_EN` falls while in SHIFT:
  - If counter ≠ 0: discard the partial word, pulse `WORD_ABORT`, clear the counter, go to IDLE. `P_DATA` keeps the last complete word.
  - If counter = 0 (word boundary): go to IDLE with no abort.
- `DES_EN` re-asserts on the cycle right after a drop: treated as a new word starting at bit 0.
- `DATA_VALID` and `WORD_ABORT` are never high in the same cycle.

## Timing
- Reset (`RST`=1 at a rising edge):
  - State IDLE; counter, shift register and `P_DATA` = 0.
  - `DATA_VALID` = 0, `WORD_ABORT` = 0, `VALID_ERR` = 0.
  - Reset overrides all inputs. A reset mid-word discards it with no `WORD_ABORT`.
- Latency: the last bit is sampled on edge N. `P_DATA` and `DATA_VALID` are registered outputs, visible after edge N and valid during cycle N+1.
- Throughput: one word per `DATA_WIDTH` cycles under continuous `DES_EN`.
- `WORD_ABORT` is asserted in the cycle after the edge that samples `DES_EN`=0.

## Configuration
- `MB_RX_VALID_CHECK_EN` defined:
  - Adds the `VALID_IN` input and the `VALID_ERR` output.
  - While sampling, `VALID_IN` must match the pattern 1,1,1,1,0,0,0,0 repeating every 8 bits, aligned to counter bits [2:0].
  - A mismatch sets `VALID_ERR`. It stays set until `RST`, or until a cycle in IDLE with `DES_EN`=0.
  - Data capture is unaffected by `VALID_ERR`.
- `MB_RX_VALID_CHECK_EN` undefined: no `VALID_IN` or `VALID_ERR` ports and no checker logic. Framing is by counter only.

## Structure
- Shared package `mb_rx_pkg` holds:
  - FSM state typedef (`MB_RX_IDLE`, `MB_RX_SHIFT`).
  - Default `DATA_WIDTH` constant.
  - 8-bit valid pattern constant 8'b0000_1111, LSB first.
- One sub-module, `mb_rx_valid_checker`, instantiated only under the macro.
  - Inputs: counter[2:0], `VALID_IN`, sample enable, clear.
  - Output: sticky error.

## Test plan
- Reset then continuous `DES_EN` with the serial stream of 0xA5A5_3C3C (LSB first) → `P_DATA`=0xA5A5_3C3C and a single `DATA_VALID` pulse, visible after the 32nd sampling edge.
- Back-to-back 0x0000_0001 then 0x8000_0000 with no gap → two `DATA_VALID` pulses exactly 32 cycles apart with correct words.
- `DES_EN` dropped after 17 bits → `WORD_ABORT` pulses once; `P_DATA` holds the prior word; the next full word 0xDEAD_BEEF is captured correctly.
- `RST` asserted at bit 20, then a full word 0x1234_5678 → no `DATA_VALID` or abort from the partial word; the new word is captured correctly.
- With the macro: correct valid pattern → `VALID_ERR`=0; `VALID_IN` forced to 0 at bit 2 → `VALID_ERR`=1 from the next cycle, cleared only after IDLE with `DES_EN`=0.
